// File: rtl/lcd_cmd_encoder.sv
// Host-side SPI master (mode 0) that serialises single ST7735 command bytes or a
// full CASET/RASET/RAMWR window write followed by RGB565 pixels.
module lcd_cmd_encoder #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CNT_W   = 17
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [31:0]      i_col_addr,
    input  logic [31:0]      i_row_addr,
    input  logic [CNT_W-1:0] i_pix_count,
    input  logic [15:0]      i_pix_data,
    input  logic             i_pix_valid,
    output logic             o_pix_ready,
    input  logic             i_cmd_req,
    input  logic [7:0]       i_cmd_code,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_spi_sclk,
    output logic             o_spi_mosi,
    output logic             o_spi_cs_n,
    output logic             o_spi_dc
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] HOLD_LAST = DIV_W'(2 * CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CS_SETUP, S_CMD_ONLY, S_CASET, S_CASET_ARG, S_RASET,
        S_RASET_ARG, S_RAMWR, S_PIX, S_CS_HOLD, S_CS_RECOV
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             sclk_q, sclk_d;
    logic             cs_n_q, cs_n_d;
    logic             dc_q, dc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             win_q, win_d;
    logic [1:0]       arg_q, arg_d;
    logic [31:0]      col_q, col_d;
    logic [31:0]      row_q, row_d;
    logic [CNT_W-1:0] pix_rem_q, pix_rem_d;
    logic [15:0]      buf_q, buf_d;
    logic             buf_full_q, buf_full_d;
    logic [7:0]       lo_q, lo_d;
    logic             lo_pend_q, lo_pend_d;
    logic             stall_q, stall_d;
    logic             pix_ready;

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    byte_sel = w[31:24];
            2'd1:    byte_sel = w[23:16];
            2'd2:    byte_sel = w[15:8];
            default: byte_sel = w[7:0];
        endcase
    endfunction

    assign pix_ready = ((state_q == S_RAMWR) || (state_q == S_PIX)) && !buf_full_q
                       && (pix_rem_q != '0);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        dc_d       = dc_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        win_d      = win_q;
        arg_d      = arg_q;
        col_d      = col_q;
        row_d      = row_q;
        pix_rem_d  = pix_rem_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        lo_d       = lo_q;
        lo_pend_d  = lo_pend_q;
        stall_d    = stall_q;

        if (pix_ready && i_pix_valid) begin
            buf_d      = i_pix_data;
            buf_full_d = 1'b1;
            pix_rem_d  = pix_rem_q - CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (i_start || i_cmd_req) begin
                    state_d    = S_CS_SETUP;
                    cs_n_d     = 1'b0;
                    busy_d     = 1'b1;
                    dc_d       = 1'b0;
                    sclk_d     = 1'b0;
                    div_d      = '0;
                    bit_d      = '0;
                    buf_full_d = 1'b0;
                    lo_pend_d  = 1'b0;
                    stall_d    = 1'b0;
                    if (i_start) begin
                        win_d     = 1'b1;
                        shreg_d   = 8'h2A;
                        col_d     = i_col_addr;
                        row_d     = i_row_addr;
                        pix_rem_d = i_pix_count;
                    end else begin
                        win_d   = 1'b0;
                        shreg_d = i_cmd_code;
                    end
                end
            end
            S_CS_SETUP: begin
                if (div_q == HALF_LAST) begin
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = win_q ? S_CASET : S_CMD_ONLY;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            // Hold covers the last bit's low half plus CLK_DIV extra low cycles.
            S_CS_HOLD: begin
                if (div_q == HOLD_LAST) begin
                    div_d   = '0;
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_CS_RECOV;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_CS_RECOV: begin
                if (div_q == HALF_LAST) begin
                    div_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                if (stall_q) begin
                    if (buf_full_q) begin
                        shreg_d    = buf_q[15:8];
                        lo_d       = buf_q[7:0];
                        lo_pend_d  = 1'b1;
                        buf_full_d = 1'b0;
                        stall_d    = 1'b0;
                        div_d      = '0;
                    end
                end else if (div_q != HALF_LAST) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q != 3'd7) begin
                            shreg_d = {shreg_q[6:0], 1'b0};
                            bit_d   = bit_q + 3'd1;
                        end else begin
                            // Byte finished on this falling edge: queue the next one now.
                            bit_d = '0;
                            case (state_q)
                                S_CASET: begin
                                    shreg_d = byte_sel(col_q, 2'd0);
                                    dc_d    = 1'b1;
                                    arg_d   = 2'd0;
                                    state_d = S_CASET_ARG;
                                end
                                S_CASET_ARG: begin
                                    if (arg_q != 2'd3) begin
                                        shreg_d = byte_sel(col_q, arg_q + 2'd1);
                                        arg_d   = arg_q + 2'd1;
                                    end else begin
                                        shreg_d = 8'h2B;
                                        dc_d    = 1'b0;
                                        state_d = S_RASET;
                                    end
                                end
                                S_RASET: begin
                                    shreg_d = byte_sel(row_q, 2'd0);
                                    dc_d    = 1'b1;
                                    arg_d   = 2'd0;
                                    state_d = S_RASET_ARG;
                                end
                                S_RASET_ARG: begin
                                    if (arg_q != 2'd3) begin
                                        shreg_d = byte_sel(row_q, arg_q + 2'd1);
                                        arg_d   = arg_q + 2'd1;
                                    end else begin
                                        shreg_d = 8'h2C;
                                        dc_d    = 1'b0;
                                        state_d = S_RAMWR;
                                    end
                                end
                                S_RAMWR, S_PIX: begin
                                    if (lo_pend_q) begin
                                        shreg_d   = lo_q;
                                        lo_pend_d = 1'b0;
                                        dc_d      = 1'b1;
                                        state_d   = S_PIX;
                                    end else if (buf_full_q) begin
                                        shreg_d    = buf_q[15:8];
                                        lo_d       = buf_q[7:0];
                                        lo_pend_d  = 1'b1;
                                        buf_full_d = 1'b0;
                                        dc_d       = 1'b1;
                                        state_d    = S_PIX;
                                    end else if (pix_rem_q == '0) begin
                                        state_d = S_CS_HOLD;
                                    end else begin
                                        dc_d    = 1'b1;
                                        stall_d = 1'b1;
                                        state_d = S_PIX;
                                    end
                                end
                                default: state_d = S_CS_HOLD;
                            endcase
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            dc_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            win_q      <= 1'b0;
            arg_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            pix_rem_q  <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            lo_q       <= '0;
            lo_pend_q  <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            dc_q       <= dc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            win_q      <= win_d;
            arg_q      <= arg_d;
            col_q      <= col_d;
            row_q      <= row_d;
            pix_rem_q  <= pix_rem_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            lo_q       <= lo_d;
            lo_pend_q  <= lo_pend_d;
            stall_q    <= stall_d;
        end
    end

    assign o_pix_ready = pix_ready;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_spi_sclk  = sclk_q;
    assign o_spi_mosi  = shreg_q[7];
    assign o_spi_cs_n  = cs_n_q;
    assign o_spi_dc    = dc_q;

endmodule

// File: tb/tb_lcd_cmd_encoder.sv
// Directed bench for lcd_cmd_encoder: a bus monitor rebuilds {DC,byte} from SCLK rises
// and checks them against a scoreboard filled when each request is issued.
module tb_lcd_cmd_encoder;

    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned CNT_W   = 17;

    logic             clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_start = 1'b0;
    logic [31:0]      i_col_addr = '0;
    logic [31:0]      i_row_addr = '0;
    logic [CNT_W-1:0] i_pix_count = '0;
    logic [15:0]      i_pix_data = '0;
    logic             i_pix_valid = 1'b0;
    logic             o_pix_ready;
    logic             i_cmd_req = 1'b0;
    logic [7:0]       i_cmd_code = '0;
    logic             o_busy, o_done, o_spi_sclk, o_spi_mosi, o_spi_cs_n, o_spi_dc;

    lcd_cmd_encoder #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_col_addr(i_col_addr),
        .i_row_addr(i_row_addr), .i_pix_count(i_pix_count), .i_pix_data(i_pix_data),
        .i_pix_valid(i_pix_valid), .o_pix_ready(o_pix_ready), .i_cmd_req(i_cmd_req),
        .i_cmd_code(i_cmd_code), .o_busy(o_busy), .o_done(o_done), .o_spi_sclk(o_spi_sclk),
        .o_spi_mosi(o_spi_mosi), .o_spi_cs_n(o_spi_cs_n), .o_spi_dc(o_spi_dc)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [8:0]  sb[$];
    logic [15:0] pix_tbl [3] = '{16'hF800, 16'h07E0, 16'h001F};

    int unsigned cyc = 0, cs_low_cnt = 0, max_low = 0, cur_low = 0, viol = 0;
    int unsigned done_cnt = 0, cs_rise_cnt = 0, bytes_seen = 0, rise_delay = 0, cs_fall_cyc = 0;
    int unsigned bitn = 0;
    bit          ready_seen = 0, first_rise_pending = 0;
    logic        prev_sclk = 1'b0, prev_cs_n = 1'b1, prev_mosi = 1'b0, prev_dc = 1'b0;
    logic [7:0]  sh = '0;
    logic        cap_dc = 1'b0;

    // Bus monitor, sampled on the falling clock edge.
    always @(negedge clk) begin
        logic [8:0] exp_b;
        cyc++;
        if (o_spi_cs_n == 1'b0) begin
            cs_low_cnt++;
            if (!o_spi_sclk) begin
                cur_low++;
                if (cur_low > max_low) max_low = cur_low;
            end else begin
                cur_low = 0;
            end
            if (prev_cs_n) begin
                cs_fall_cyc = cyc;
                first_rise_pending = 1;
            end
            if (o_spi_sclk && !prev_sclk) begin
                if (first_rise_pending) begin
                    rise_delay = cyc - cs_fall_cyc;
                    first_rise_pending = 0;
                end
                if (bitn == 0) cap_dc = o_spi_dc;
                sh = {sh[6:0], o_spi_mosi};
                bitn++;
                if (bitn == 8) begin
                    bitn = 0;
                    bytes_seen++;
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_err++;
                        $error("FAIL unexpected_byte observed=%h expected=none", {cap_dc, sh});
                    end else begin
                        exp_b = sb.pop_front();
                        assert ({cap_dc, sh} === exp_b) else begin
                            n_err++;
                            $error("FAIL byte%0d observed=%h expected=%h", bytes_seen, {cap_dc, sh}, exp_b);
                        end
                    end
                end
            end
            if (prev_sclk && o_spi_sclk && (o_spi_mosi !== prev_mosi || o_spi_dc !== prev_dc)) viol++;
        end else begin
            cur_low = 0;
            bitn = 0;
            if (!prev_cs_n) cs_rise_cnt++;
        end
        if (o_done) done_cnt++;
        if (o_pix_ready) ready_seen = 1;
        prev_sclk = o_spi_sclk;
        prev_cs_n = o_spi_cs_n;
        prev_mosi = o_spi_mosi;
        prev_dc   = o_spi_dc;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        cs_low_cnt = 0; max_low = 0; viol = 0; done_cnt = 0; cs_rise_cnt = 0;
        bytes_seen = 0; rise_delay = 0; ready_seen = 0;
    endtask

    function automatic int unsigned cs_low_exp(input int unsigned nbytes);
        return CLK_DIV + nbytes * 16 * CLK_DIV + CLK_DIV;
    endfunction

    task automatic push_window(input logic [31:0] col, input logic [31:0] row, input int unsigned n);
        sb.push_back({1'b0, 8'h2A});
        for (int i = 0; i < 4; i++) sb.push_back({1'b1, col[8*(3-i) +: 8]});
        sb.push_back({1'b0, 8'h2B});
        for (int i = 0; i < 4; i++) sb.push_back({1'b1, row[8*(3-i) +: 8]});
        sb.push_back({1'b0, 8'h2C});
        for (int k = 0; k < int'(n); k++) begin
            sb.push_back({1'b1, pix_tbl[k][15:8]});
            sb.push_back({1'b1, pix_tbl[k][7:0]});
        end
    endtask

    task automatic send_pix(input logic [15:0] d, input int unsigned budget, output bit ok);
        i_pix_valid = 1'b1;
        i_pix_data  = d;
        ok = 0;
        for (int t = 0; t < int'(budget); t++) begin
            if (o_pix_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        i_pix_valid = 1'b0;
    endtask

    task automatic wait_done(input int unsigned budget);
        bit seen = 0;
        logic b1, b2;
        for (int t = 0; t < int'(budget); t++) begin
            @(negedge clk);
            if (o_done) begin
                seen = 1;
                break;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("done_cs_busy", {o_spi_cs_n, o_busy, o_spi_sclk}, 3'b110);
            @(negedge clk); b1 = o_busy;
            @(negedge clk); b2 = o_busy;
            check("busy_recov", {b1, b2}, 2'b10);
        end
    endtask

    task automatic run_window(input logic [31:0] col, input logic [31:0] row, input int unsigned n,
                              input int unsigned gap, input bit dual, input bit late_req,
                              output int unsigned acc);
        int unsigned a = 0;
        clear_stats();
        push_window(col, row, n);
        i_col_addr = col; i_row_addr = row; i_pix_count = CNT_W'(n);
        i_start = 1'b1; i_cmd_req = dual; i_cmd_code = 8'h29;
        @(negedge clk);
        i_start = 1'b0; i_cmd_req = 1'b0;
        check("win_first", {o_busy, o_spi_cs_n, o_spi_mosi, o_spi_dc}, 4'b1000);
        fork
            wait_done(3000);
            begin
                for (int k = 0; k <= int'(n) && k < 3; k++) begin
                    bit ok;
                    if (k == 1) repeat (gap) @(negedge clk);
                    send_pix(pix_tbl[k], (k == int'(n)) ? 300 : 1500, ok);
                    if (ok) a++;
                end
            end
            begin
                if (late_req) begin
                    repeat (100) @(negedge clk);
                    i_cmd_code = 8'h11; i_cmd_req = 1'b1; i_start = 1'b1;
                    @(negedge clk);
                    i_cmd_req = 1'b0; i_start = 1'b0;
                end
            end
        join
        acc = a;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned acc;
        bit ok, seen;

        repeat (3) @(negedge clk);
        check("reset_during", {o_spi_cs_n, o_spi_sclk, o_busy, o_done}, 4'b1000);
        i_rst_n = 1'b1;
        @(negedge clk);
        check("reset_outs", {o_spi_cs_n, o_spi_sclk, o_spi_mosi, o_spi_dc, o_busy, o_done, o_pix_ready},
              7'b1000000);

        // T1: single command 0x29
        clear_stats();
        sb.push_back({1'b0, 8'h29});
        i_cmd_code = 8'h29; i_cmd_req = 1'b1;
        @(negedge clk);
        i_cmd_req = 1'b0;
        check("t1_first", {o_busy, o_spi_cs_n, o_spi_mosi, o_spi_dc, o_spi_sclk}, 5'b10000);
        wait_done(200);
        check("t1_cs_low", cs_low_cnt, cs_low_exp(1));
        check("t1_rise_delay", rise_delay, CLK_DIV);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_viol", viol, 0);
        check("t1_sb_left", sb.size(), 0);

        // T2: full window write, two pixels, no starvation
        run_window(32'h0000007F, 32'h0000009F, 2, 0, 1'b0, 1'b0, acc);
        check("t2_acc", acc, 2);
        check("t2_cs_low", cs_low_cnt, cs_low_exp(15));
        check("t2_max_low", max_low, 2 * CLK_DIV);
        check("t2_cs_rise", cs_rise_cnt, 1);
        check("t2_viol", viol, 0);
        check("t2_sb_left", sb.size(), 0);

        // T3: second pixel arrives late enough to starve the shifter
        run_window(32'h0000007F, 32'h0000009F, 2, 150, 1'b0, 1'b0, acc);
        check("t3_acc", acc, 2);
        check("t3_stalled", 32'(max_low > 40), 32'd1);
        check("t3_cs_longer", 32'(cs_low_cnt > cs_low_exp(15)), 32'd1);
        check("t3_cs_rise", cs_rise_cnt, 1);
        check("t3_viol", viol, 0);
        check("t3_sb_left", sb.size(), 0);

        // T4: zero pixel count
        run_window(32'h00100020, 32'h00300040, 0, 0, 1'b0, 1'b0, acc);
        check("t4_acc", acc, 0);
        check("t4_ready_seen", 32'(ready_seen), 32'd0);
        check("t4_cs_low", cs_low_cnt, cs_low_exp(11));
        check("t4_sb_left", sb.size(), 0);

        // T5: simultaneous start+cmd, then requests while busy
        run_window(32'h12345678, 32'h9ABCDEF0, 0, 0, 1'b1, 1'b1, acc);
        repeat (60) @(negedge clk);
        check("t5_idle", {o_busy, o_spi_cs_n}, 2'b01);
        check("t5_cs_low", cs_low_cnt, cs_low_exp(11));
        check("t5_done_cnt", done_cnt, 1);
        check("t5_sb_left", sb.size(), 0);

        // T6: asynchronous reset in the middle of pixel data
        clear_stats();
        push_window(32'h0000007F, 32'h0000009F, 2);
        i_col_addr = 32'h0000007F; i_row_addr = 32'h0000009F; i_pix_count = CNT_W'(2);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        send_pix(pix_tbl[0], 1500, ok);
        check("t6_pix_acc", 32'(ok), 32'd1);
        seen = 0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (bytes_seen >= 12) begin
                seen = 1;
                break;
            end
        end
        check("t6_reach_pix", 32'(seen), 32'd1);
        #2 i_rst_n = 1'b0;
        #1 check("t6_abort", {o_spi_cs_n, o_spi_sclk, o_busy, o_done, o_pix_ready}, 5'b10000);
        repeat (3) @(negedge clk);
        check("t6_no_done", done_cnt, 0);
        sb.delete();
        i_rst_n = 1'b1;
        @(negedge clk);
        run_window(32'h0000007F, 32'h0000009F, 2, 0, 1'b0, 1'b0, acc);
        check("t6_t2_acc", acc, 2);
        check("t6_t2_cs_low", cs_low_cnt, cs_low_exp(15));
        check("t6_t2_sb_left", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
